// File: rtl/mux_pkg.sv
// Shared constants and output-stage state type for the four-to-one stream merger.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way grant selector: searches upward from last+1 with wrap and grants the
// first requesting channel; gnt is one-hot when enabled and any req is set.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  input  logic              enable,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic [SEL_W-1:0] cand_s;
  logic             found_s;

  // Wrap-around search; the fourth candidate is the last winner itself.
  always_comb begin
    gnt     = {NUM_CH{1'b0}};
    gnt_idx = last;
    cand_s  = {SEL_W{1'b0}};
    found_s = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand_s = last + SEL_W'(k);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        gnt_idx = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    if (enable && found_s) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = {NUM_CH{1'b0}};
    end
  end

endmodule

// File: rtl/mux_fourtoone_rr.sv
// Merges four valid/ready streams into one registered output stage.
// Define MUX_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module mux_fourtoone_rr
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  stage_e            state_r, next_state_s;
  logic [DATA_W-1:0] out_data_r, next_data_s;
  logic [SEL_W-1:0]  out_sel_r, next_sel_s;
  logic [SEL_W-1:0]  arb_last_s;
  logic [SEL_W-1:0]  gnt_idx_s;
  logic [NUM_CH-1:0] gnt_s;
  logic              can_load_s;
  logic              in_xfer_s;

  assign can_load_s = (state_r == EMPTY) || out_ready;
  assign in_xfer_s  = |gnt_s;
  assign in_ready   = gnt_s;
  assign out_valid  = (state_r == FULL);
  assign out_data   = out_data_r;
  assign out_sel    = out_sel_r;

`ifdef MUX_FIXED_PRIO_EN
  // Starting the search after channel 3 makes channel 0 the highest priority.
  assign arb_last_s = SEL_W'(NUM_CH - 1);
`else
  logic [SEL_W-1:0] last_grant_r, next_last_s;

  // Round-robin pointer moves only when an input word is actually taken.
  always_comb begin
    if (in_xfer_s) begin
      next_last_s = gnt_idx_s;
    end else begin
      next_last_s = last_grant_r;
    end
  end

  // Round-robin pointer register; channel 0 goes first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= SEL_W'(NUM_CH - 1);
    end else begin
      last_grant_r <= next_last_s;
    end
  end

  assign arb_last_s = last_grant_r;
`endif

  rr_arbiter4 u_arb (
    .req     (in_valid),
    .last    (arb_last_s),
    .enable  (can_load_s & rst_n),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Output stage next-state: a load wins over a drain so full throughput is kept.
  always_comb begin
    next_state_s = state_r;
    next_data_s  = out_data_r;
    next_sel_s   = out_sel_r;
    case (state_r)
      EMPTY: begin
        if (in_xfer_s) begin
          next_state_s = FULL;
          next_data_s  = in_data[gnt_idx_s*DATA_W +: DATA_W];
          next_sel_s   = gnt_idx_s;
        end else begin
          next_state_s = EMPTY;
        end
      end
      FULL: begin
        if (in_xfer_s) begin
          next_state_s = FULL;
          next_data_s  = in_data[gnt_idx_s*DATA_W +: DATA_W];
          next_sel_s   = gnt_idx_s;
        end else if (out_ready) begin
          next_state_s = EMPTY;
        end else begin
          next_state_s = FULL;
        end
      end
      default: begin
        next_state_s = EMPTY;
      end
    endcase
  end

  // Output stage registers; a held word is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      out_data_r <= {DATA_W{1'b0}};
      out_sel_r  <= {SEL_W{1'b0}};
    end else begin
      state_r    <= next_state_s;
      out_data_r <= next_data_s;
      out_sel_r  <= next_sel_s;
    end
  end

endmodule

// File: doc/mux_fourtoone_rr.md
MUX_FOURTOONE_RR -- requirements
Module: mux_fourtoone_rr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the width of each channel data word.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous assert, active-low.
REQ-004 SHALL have port in_valid, input, 4, per-channel word-available flags; bit i is channel i.
REQ-005 SHALL have port in_data, input, 4*DATA_W, channel words; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have port in_ready, output, 4, per-channel accept strobe; one-hot or zero.
REQ-007 SHALL have port out_valid, output, 1, output register holds a word.
REQ-008 SHALL have port out_data, output, DATA_W, merged output word.
REQ-009 SHALL have port out_sel, output, 2, source channel index of out_data.
REQ-010 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-011 SHALL merge four valid/ready input streams into one output stream; this is the collecting end of a 1:4 demux.
REQ-012 SHALL hold out_valid, out_data and out_sel in a single registered output stage with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL treat an input transfer as in_valid[i] & in_ready[i], and an output transfer as out_valid & out_ready.
REQ-014 SHALL set can_load = EMPTY or (FULL and out_ready).
REQ-015 SHALL drive in_ready combinationally: the granted channel's bit is 1 only when can_load=1 and at least one in_valid bit is 1; all other bits are 0.
REQ-016 SHALL grant round-robin: search channels starting at (last_grant+1) mod 4, upward with wrap, and grant the first with in_valid=1.
REQ-017 SHALL update last_grant only on an input transfer.
REQ-018 SHALL load the granted channel's word and index into out_data/out_sel on the clock edge of the input transfer, so latency is 1 cycle.
REQ-019 SHALL sustain one word per cycle when out_ready=1 continuously: a simultaneous output transfer and input transfer keeps the stage FULL with the new word.
REQ-020 SHALL go FULL->EMPTY only on an output transfer with no input transfer in the same cycle.
REQ-021 SHALL keep out_data and out_sel unchanged while out_valid=1 and out_ready=0.
REQ-022 SHALL drive in_ready=0000 when in_valid=0000 and leave last_grant unchanged.
REQ-023 SHALL not depend on in_data of non-granted channels.

Reset
REQ-024 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_sel=0, state=EMPTY and last_grant=3, so that channel 0 has first priority after reset.
REQ-025 SHALL drop any word held at reset assertion mid-operation, with no transfer completed.
REQ-026 SHALL drive in_ready=0000 while rst_n=0.

Configuration
REQ-027 SHALL use macro MUX_FIXED_PRIO_EN: when defined, the grant is fixed priority (lowest-indexed valid channel wins) and last_grant is not implemented; when undefined, the grant is round-robin per REQ-016.

Structure
REQ-028 SHALL take NUM_CH=4, SEL_W=2 and the EMPTY/FULL state enumeration from shared package mux_pkg.
REQ-029 SHALL implement grant selection in sub-module rr_arbiter4, with inputs req[3:0], last[1:0] and enable, and outputs gnt[3:0] (one-hot) and gnt_idx[1:0].

Verification
REQ-030 SHALL check the following: after reset, in_valid=0001, in_data ch0=8'hA5, out_ready=1 -> in_ready=0001; next cycle out_valid=1, out_data=A5, out_sel=0.
REQ-031 SHALL check the following: in_valid=1111 held, out_ready=1, channel i data=8'h10+i -> out_sel sequence 0,1,2,3,0, one word per cycle.
REQ-032 SHALL check the following: stage FULL with 8'h3C, out_ready=0 for 3 cycles, other channels valid -> out_data stays 3C, in_ready=0000 throughout; out_ready=1 -> next word loads the same cycle.
REQ-033 SHALL check the following: last_grant=2, in_valid=0011 -> channel 0 granted (wrap-around), then channel 1.
REQ-034 SHALL check the following: rst_n pulled low while FULL with 8'h77 -> out_valid=0 immediately, without waiting for clk; after release channel 0 wins.
REQ-035 SHALL check the following: with MUX_FIXED_PRIO_EN defined, in_valid=1010 held, out_ready=1 -> out_sel=1 every cycle and channel 3 never granted.
